// File: rtl/axis_fifo_buf_pkg.sv
// Shared helpers for the AXI4-Stream FIFO buffer: stored entry width and
// level/packet counter width.
package axis_fifo_buf_pkg;

  // One stored entry is {tlast, tkeep, tdata}.
  function automatic int entry_w(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  // Counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_buf_ram.sv
// Simple dual-port storage for axis_fifo_buf: one synchronous write port and
// an asynchronous read port, so it can map onto distributed RAM.
module axis_fifo_buf_ram
  import axis_fifo_buf_pkg::*;
#(
  parameter int WIDTH = 73,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_fifo_buf.sv
// AXI4-Stream FIFO buffer with first-word-fall-through output and fill level.
// Define AXIS_FIFO_BUF_PKT_MODE_EN for store-and-forward packet mode.
module axis_fifo_buf
  import axis_fifo_buf_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  localparam int KEEP_W = DATA_W / 8,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              s_TVALID,
  output logic              s_TREADY,
  input  logic [DATA_W-1:0] s_TDATA,
  input  logic [KEEP_W-1:0] s_TKEEP,
  input  logic              s_TLAST,
  output logic              m_TVALID,
  input  logic              m_TREADY,
  output logic [DATA_W-1:0] m_TDATA,
  output logic [KEEP_W-1:0] m_TKEEP,
  output logic              m_TLAST,
  output logic [CNT_W-1:0]  LEVEL
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(DATA_W);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] level;
  logic             wr;
  logic             rd;
  logic [EW-1:0]    rd_entry;

  // Ready depends only on the level, never on m_TREADY: full means full.
  assign s_TREADY = !ARESET && (level < FULL_LVL);
  assign wr       = s_TVALID && s_TREADY;
  assign rd       = m_TVALID && m_TREADY;
  assign LEVEL    = level;

  assign {m_TLAST, m_TKEEP, m_TDATA} = rd_entry;

  axis_fifo_buf_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .ACLK    (ACLK),
    .wr_en   (wr),
    .wr_addr (wr_ptr),
    .wr_data ({s_TLAST, s_TKEEP, s_TDATA}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef AXIS_FIFO_BUF_PKT_MODE_EN
  logic [CNT_W-1:0] pkt;
  logic             wr_last;
  logic             rd_last;

  assign wr_last = wr && s_TLAST;
  assign rd_last = rd && m_TLAST;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pkt <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pkt <= pkt + 1'b1;
        2'b01:   pkt <= pkt - 1'b1;
        default: pkt <= pkt;
      endcase
    end
  end

  // A full buffer with no complete packet cuts through to avoid deadlock.
  assign m_TVALID = !ARESET && (level != '0) &&
                    ((pkt != '0) || (level == FULL_LVL));
`else
  assign m_TVALID = !ARESET && (level != '0);
`endif

endmodule

// File: tb/tb_axis_fifo_buf.sv
// Self-checking bench for axis_fifo_buf (DATA_W=64, DEPTH=16): vector table,
// fill/drain, scoreboarded streaming, mid-operation reset and packet mode.
module tb_axis_fifo_buf;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          s_TVALID;
  logic          s_TREADY;
  logic [DW-1:0] s_TDATA;
  logic [KW-1:0] s_TKEEP;
  logic          s_TLAST;
  logic          m_TVALID;
  logic          m_TREADY;
  logic [DW-1:0] m_TDATA;
  logic [KW-1:0] m_TKEEP;
  logic          m_TLAST;
  logic [CW-1:0] LEVEL;

  int n_cmp = 0;
  int n_bad = 0;

  axis_fifo_buf #(.DATA_W(DW), .DEPTH(D)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
    .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST),
    .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .m_TDATA(m_TDATA),
    .m_TKEEP(m_TKEEP), .m_TLAST(m_TLAST), .LEVEL(LEVEL)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    logic          rst;
    logic          sv;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic [CW-1:0] e_lvl;
    logic [DW-1:0] e_d;
    logic [KW-1:0] e_k;
    logic          e_l;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic to_edge();
    @(posedge ACLK);
    #1;
  endtask

  function automatic ent_t mk(input int seq, input int lastmode, input int n);
    ent_t e;
    e.d = {32'(seq) ^ 32'hA5A5_0000, 32'(seq) * 32'h9E37_79B9};
    e.k = 8'(seq * 7 + 1);
    e.l = (lastmode == 0) ? (seq % 5 == 4) : 1'b0;
    if (seq == n - 1) e.l = 1'b1;
    return e;
  endfunction

  // Scoreboarded streaming from an empty buffer with an independent level model.
  task automatic stream(input int n, input int pv, input int pr,
                        input int lastmode, input bit chk_tput);
    ent_t q[$];
    ent_t cur;
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    int   lvl  = 0;
    int   pkt  = 0;
    bit   sr_e, mv_e, wr, rd, rd_last;
    while ((sent < n || got < n) && cyc < 20 * n + 100) begin
      cur      = mk(sent, lastmode, n);
      s_TVALID = (sent < n) && ($urandom_range(99) < pv);
      s_TDATA  = cur.d;
      s_TKEEP  = cur.k;
      s_TLAST  = cur.l;
      m_TREADY = ($urandom_range(99) < pr);
      @(negedge ACLK);
      sr_e = (lvl < D);
`ifdef AXIS_FIFO_BUF_PKT_MODE_EN
      mv_e = (lvl != 0) && (pkt != 0 || lvl == D);
`else
      mv_e = (lvl != 0);
`endif
      chk("stream_s_TREADY", s_TREADY, sr_e);
      chk("stream_m_TVALID", m_TVALID, mv_e);
      chk("stream_LEVEL", LEVEL, lvl);
      wr = s_TVALID && sr_e;
      rd = mv_e && m_TREADY;
      rd_last = 1'b0;
      if (rd) begin
        if (q.size() == 0) begin
          chk("stream_underflow", 1, 0);
        end else begin
          chk("stream_word", {m_TLAST, m_TKEEP, m_TDATA}, q[0]);
          rd_last = q[0].l;
          void'(q.pop_front());
        end
        got++;
      end
      if (wr) begin
        q.push_back(cur);
        sent++;
      end
      lvl = lvl + int'(wr) - int'(rd);
      pkt = pkt + int'(wr && cur.l) - int'(rd_last);
      to_edge();
      cyc++;
    end
    s_TVALID = 1'b0;
    m_TREADY = 1'b0;
    chk("stream_words_out", got, n);
    if (chk_tput) chk("stream_full_rate_cycles", cyc, n + 1);
  endtask

  vec_t tbl[9];

  initial begin
    ARESET   = 1'b1;
    s_TVALID = 1'b0;
    s_TDATA  = '0;
    s_TKEEP  = '0;
    s_TLAST  = 1'b0;
    m_TREADY = 1'b0;
    to_edge();
    to_edge();

`ifndef AXIS_FIFO_BUF_PKT_MODE_EN
    //         rst sv d                      k      l  mr  sr mv lvl e_d                    e_k    e_l
    tbl[0] = '{1, 0, 64'h0,                 8'h00, 0, 0,  0, 0, 0, 64'h0,                 8'h00, 0};
    tbl[1] = '{0, 1, 64'hA5A5_0000_0000_0001, 8'hFF, 1, 0, 1, 0, 0, 64'h0,                 8'h00, 0};
    tbl[2] = '{0, 0, 64'h0,                 8'h00, 0, 0,  1, 1, 1, 64'hA5A5_0000_0000_0001, 8'hFF, 1};
    tbl[3] = '{0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 1, 64'hA5A5_0000_0000_0001, 8'hFF, 1};
    tbl[4] = '{0, 0, 64'h0,                 8'h00, 0, 1,  1, 0, 0, 64'h0,                 8'h00, 0};
    tbl[5] = '{0, 1, 64'h11,                8'h0F, 0, 1,  1, 0, 0, 64'h0,                 8'h00, 0};
    tbl[6] = '{0, 1, 64'h22,                8'h01, 1, 1,  1, 1, 1, 64'h11,                8'h0F, 0};
    tbl[7] = '{0, 0, 64'h0,                 8'h00, 0, 1,  1, 1, 1, 64'h22,                8'h01, 1};
    tbl[8] = '{0, 0, 64'h0,                 8'h00, 0, 0,  1, 0, 0, 64'h0,                 8'h00, 0};
    for (int i = 0; i < 9; i++) begin
      ARESET   = tbl[i].rst;
      s_TVALID = tbl[i].sv;
      s_TDATA  = tbl[i].d;
      s_TKEEP  = tbl[i].k;
      s_TLAST  = tbl[i].l;
      m_TREADY = tbl[i].mr;
      @(negedge ACLK);
      chk($sformatf("vec%0d_s_TREADY", i), s_TREADY, tbl[i].e_sr);
      chk($sformatf("vec%0d_m_TVALID", i), m_TVALID, tbl[i].e_mv);
      chk($sformatf("vec%0d_LEVEL", i), LEVEL, tbl[i].e_lvl);
      if (tbl[i].e_mv)
        chk($sformatf("vec%0d_word", i), {m_TLAST, m_TKEEP, m_TDATA},
            {tbl[i].e_l, tbl[i].e_k, tbl[i].e_d});
      to_edge();
    end
`else
    ARESET = 1'b0;
`endif

    // Fill to full, then offer a 17th word while reading.
    for (int i = 0; i < D; i++) begin
      s_TVALID = 1'b1;
      s_TDATA  = 64'(i);
      s_TKEEP  = 8'(i);
      s_TLAST  = (i == D - 1);
      m_TREADY = 1'b0;
      @(negedge ACLK);
      chk("fill_s_TREADY", s_TREADY, 1);
      to_edge();
    end
    s_TVALID = 1'b0;
    @(negedge ACLK);
    chk("full_LEVEL", LEVEL, D);
    chk("full_s_TREADY", s_TREADY, 0);
    chk("full_m_TVALID", m_TVALID, 1);
    to_edge();
    s_TVALID = 1'b1;
    s_TDATA  = 64'hDEAD_BEEF_DEAD_BEEF;
    s_TKEEP  = 8'hAA;
    s_TLAST  = 1'b1;
    m_TREADY = 1'b1;
    @(negedge ACLK);
    chk("full_rd_s_TREADY", s_TREADY, 0);
    chk("drain_word0", {m_TLAST, m_TKEEP, m_TDATA}, {1'b0, 8'h00, 64'h0});
    to_edge();
    s_TVALID = 1'b0;
    for (int i = 1; i < D; i++) begin
      @(negedge ACLK);
      chk("drain_m_TVALID", m_TVALID, 1);
      chk($sformatf("drain_word%0d", i), {m_TLAST, m_TKEEP, m_TDATA},
          {(i == D - 1), 8'(i), 64'(i)});
      to_edge();
    end
    @(negedge ACLK);
    chk("drained_LEVEL", LEVEL, 0);
    chk("drained_m_TVALID", m_TVALID, 0);
    to_edge();
    m_TREADY = 1'b0;

    // Mid-operation reset with seven words stored.
    for (int i = 0; i < 7; i++) begin
      s_TVALID = 1'b1;
      s_TDATA  = 64'h700 + 64'(i);
      s_TKEEP  = 8'hFF;
      s_TLAST  = 1'b0;
      to_edge();
    end
    s_TVALID = 1'b0;
    @(negedge ACLK);
    chk("prerst_LEVEL", LEVEL, 7);
    to_edge();
    ARESET   = 1'b1;
    s_TVALID = 1'b1;
    m_TREADY = 1'b1;
    @(negedge ACLK);
    chk("rst_s_TREADY", s_TREADY, 0);
    chk("rst_m_TVALID", m_TVALID, 0);
    to_edge();
    ARESET   = 1'b0;
    s_TVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("postrst_LEVEL", LEVEL, 0);
      chk("postrst_m_TVALID", m_TVALID, 0);
      chk("postrst_s_TREADY", s_TREADY, 1);
      to_edge();
    end
    m_TREADY = 1'b0;
    s_TVALID = 1'b1;
    s_TDATA  = 64'h0000_0000_0000_BEEF;
    s_TKEEP  = 8'h03;
    s_TLAST  = 1'b1;
    to_edge();
    s_TVALID = 1'b0;
    m_TREADY = 1'b1;
    @(negedge ACLK);
    chk("postrst_first_word", {m_TLAST, m_TKEEP, m_TDATA}, {1'b1, 8'h03, 64'hBEEF});
    to_edge();
    @(negedge ACLK);
    chk("postrst_empty_LEVEL", LEVEL, 0);
    to_edge();
    m_TREADY = 1'b0;

`ifdef AXIS_FIFO_BUF_PKT_MODE_EN
    // Five-word packet is held until its last word is stored.
    m_TREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_TVALID = 1'b1;
      s_TDATA  = 64'h500 + 64'(i);
      s_TKEEP  = 8'hFF;
      s_TLAST  = (i == 4);
      @(negedge ACLK);
      chk("pkt5_hold_m_TVALID", m_TVALID, 0);
      to_edge();
    end
    s_TVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("pkt5_out_m_TVALID", m_TVALID, 1);
      chk("pkt5_out_word", {m_TLAST, m_TDATA}, {(i == 4), 64'h500 + 64'(i)});
      to_edge();
    end
    @(negedge ACLK);
    chk("pkt5_done_LEVEL", LEVEL, 0);
    to_edge();
    m_TREADY = 1'b0;
    // 20 words without LAST force cut-through at full; a final LAST word flushes.
    stream(21, 100, 100, 1, 1'b0);
    stream(300, 50, 50, 0, 1'b0);
`else
    stream(1000, 50, 50, 0, 1'b0);
    stream(64, 100, 100, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
